fir_mac_engine: RTL and testbench
=================================

// Module: fir_mac_engine
// PURPOSE
//  8-tap FIR datapath that consumes the 3-bit tap index contador_up from up_counter, which runs at N*fs.
//  Holds the sample delay line and does one signed multiply-accumulate per clk.
//  Emits one filtered sample per 8-clk frame. Sits between the 48 kHz sample source and the audio output stage.
// PARAMETERS
//  DATA_W     16  sample width, signed Q1.15
//  COEF_W     16  coefficient width, signed Q1.15
//  N_TAPS     8   taps; must equal counter modulus (2**3)
//  ACC_W      35  accumulator width = DATA_W+COEF_W+3 (no overflow over 8 taps)
//  OUT_SHIFT  15  right shift from accumulator to output
// PORTS
//  clk           in   1       N*fs clock, same clock as up_counter
//  reset         in   1       asynchronous, active-low; all state cleared while low
//  clear         in   1       sync clear: zero delay line, acc, pending; state->IDLE
//  sample_in     in   DATA_W  new input sample, signed
//  sample_valid  in   1       1-clk strobe, sample_in valid
//  contador_up   in   3       tap index from up_counter, 0..7, increments every clk
//  sample_out    out  DATA_W  filtered sample, signed, held between updates
//  out_valid     out  1       1-clk pulse when sample_out updates
//  overrun       out  1       1-clk pulse: unconsumed pending sample overwritten
//  underrun      out  1       1-clk pulse: frame boundary reached with no pending sample
// BEHAVIOUR
//  Reset (reset=0): sample_out=0, out_valid=0, overrun=0, underrun=0.
//    Also x[0..7]=0, acc=0, pend_data=0, pend_flag=0, state=IDLE.
//  Priority: reset > clear > normal operation.
//  Frame edge = rising clk edge with contador_up==7.
//  Input capture: sample_valid=1 -> pend_data<=sample_in, pend_flag<=1.
//    If pend_flag already 1 and not consumed this edge -> overwrite, overrun=1 for 1 clk.
//  Consumption, at a frame edge: x[0] <= pend_data, x[k] <= x[k-1], pend_flag <= 0.
//    Bypass: pend_flag=0 and sample_valid=1 in the same cycle -> x[0]<=sample_in; nothing left pending.
//    Both set: the old pend_data is consumed; sample_in becomes the new pending. Not an overrun.
//  FSM:
//    IDLE: no MAC, out_valid=0; at a frame edge with a sample available -> consume, go RUN.
//    RUN:  per clk, prod = x[t]*coef[t], t=contador_up (32b signed).
//      t==0: acc <= sext(prod); t=1..7: acc <= acc + sext(prod).
//      Frame edge: y = acc + prod7; sample_out <= sat16((y + 2**(OUT_SHIFT-1)) >>> OUT_SHIFT); out_valid=1.
//      Same frame edge: consume the pending sample, or if none: shift in pend_data again (repeat last), underrun=1.
//      Stays in RUN until reset/clear.
//  Latency: a sample enters x[0] at frame edge F; its first contribution appears on sample_out at edge F+8 clk.
//  sat16: clamp to [-32768, 32767].
//  Mid-frame reset/clear: pending work discarded; restart requires a new sample at a frame edge.
//  contador_up is trusted to increment by 1 and wrap 7->0; no resync logic.
// STRUCTURE
//  fir_pkg: DATA_W/COEF_W/ACC_W/N_TAPS constants, state encoding (IDLE=0, RUN=1).
//    Also holds the coefficient table: c0..c7 = 0x0400,0x0C00,0x1400,0x1C00,0x1C00,0x1400,0x0C00,0x0400 (sum 1.0).
//  Sub-module fir_coef_rom: combinational case table, addr[2:0] -> coef[15:0].
//  Top holds: delay line, pending register, multiplier, accumulator, FSM, output saturation.
// TESTING
//  1. Impulse 0x7FFF then zeros, one per frame -> out seq 0x0400,0x0C00,0x1400,0x1C00,0x1C00,0x1400,0x0C00,0x0400, then 0x0000.
//  2. DC 0x4000 every frame -> from the 8th output on, sample_out=0x4000 steady; DC -0x8000 -> 0x8000.
//  3. Two sample_valid pulses in one frame, neither on a frame edge -> overrun=1 once; second value used.
//  4. No sample_valid for one frame in RUN -> underrun=1 at that edge; last sample repeated in the delay line.
//  5. reset low mid-frame (contador_up=3) -> all outputs 0 immediately; after release, no out_valid until sample+frame edge.
//  6. sample_valid coincident with a frame edge, pend_flag=0 -> bypass; no overrun.
//     Then clear=1 -> next output after restart reflects a zeroed delay line.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, FSM state type and coefficient table for the
// 8-tap FIR MAC engine.
//   FIR_DATA_W / FIR_COEF_W : Q1.15 sample and coefficient widths
//   FIR_N_TAPS / FIR_TAP_W  : tap count and tap-index width (matches up_counter)
//   FIR_ACC_W               : accumulator width, 3 guard bits over the product
//   FIR_OUT_SHIFT           : accumulator-to-output scaling shift
package fir_pkg;

    localparam int FIR_DATA_W    = 16;
    localparam int FIR_COEF_W    = 16;
    localparam int FIR_N_TAPS    = 8;
    localparam int FIR_TAP_W     = 3;
    localparam int FIR_ACC_W     = FIR_DATA_W + FIR_COEF_W + 3;
    localparam int FIR_OUT_SHIFT = 15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fir_state_e;

    // Symmetric low-pass taps, Q1.15, summing to exactly 1.0.
    // Entry [k] is coefficient c_k.
    localparam logic [FIR_N_TAPS-1:0][FIR_COEF_W-1:0] FIR_COEF_TABLE = {
        16'h0400, 16'h0C00, 16'h1400, 16'h1C00,
        16'h1C00, 16'h1400, 16'h0C00, 16'h0400
    };

endpackage

// File: rtl/fir_coef_rom.sv
// fir_coef_rom: combinational coefficient lookup for the FIR MAC engine.
//   addr : tap index 0..7
//   coef : signed Q1.15 coefficient for that tap
module fir_coef_rom
    import fir_pkg::*;
(
    input  logic        [FIR_TAP_W-1:0]  addr,
    output logic signed [FIR_COEF_W-1:0] coef
);

    always_comb begin
        coef = '0;
        case (addr)
            3'd0: coef = $signed(FIR_COEF_TABLE[0]);
            3'd1: coef = $signed(FIR_COEF_TABLE[1]);
            3'd2: coef = $signed(FIR_COEF_TABLE[2]);
            3'd3: coef = $signed(FIR_COEF_TABLE[3]);
            3'd4: coef = $signed(FIR_COEF_TABLE[4]);
            3'd5: coef = $signed(FIR_COEF_TABLE[5]);
            3'd6: coef = $signed(FIR_COEF_TABLE[6]);
            3'd7: coef = $signed(FIR_COEF_TABLE[7]);
            default: coef = '0;
        endcase
    end

endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: 8-tap FIR datapath, one signed multiply-accumulate per clk,
// tap index supplied by an external up_counter running at N*fs.
//   clk          : N*fs clock (shared with up_counter)
//   reset        : asynchronous, active-low; clears all state
//   clear        : synchronous clear of delay line, accumulator, pending; FSM to IDLE
//   sample_in    : signed input sample, qualified by sample_valid (1-clk strobe)
//   contador_up  : tap index 0..7; the edge with index 7 is the frame edge
//   sample_out   : filtered, rounded, saturated sample; held between updates
//   out_valid    : 1-clk pulse when sample_out updates
//   overrun      : 1-clk pulse when an unconsumed pending sample is overwritten
//   underrun     : 1-clk pulse when a RUN frame edge finds no sample available
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int DATA_W    = FIR_DATA_W,
    parameter int ACC_W     = FIR_ACC_W,
    parameter int OUT_SHIFT = FIR_OUT_SHIFT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    input  logic        [2:0]        contador_up,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     out_valid,
    output logic                     overrun,
    output logic                     underrun
);

    localparam int COEF_W = FIR_COEF_W;
    localparam int N_TAPS = FIR_N_TAPS;
    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(2 ** (OUT_SHIFT - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [DATA_W-1:0] x_q [N_TAPS];
    logic signed [DATA_W-1:0] x_d [N_TAPS];
    logic signed [DATA_W-1:0] pend_data_q, pend_data_d;
    logic                     pend_flag_q, pend_flag_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    fir_state_e               state_q, state_d;
    logic signed [DATA_W-1:0] sample_out_q, sample_out_d;
    logic                     out_valid_q, out_valid_d;
    logic                     overrun_q, overrun_d;
    logic                     underrun_q, underrun_d;

    logic signed [COEF_W-1:0] coef;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  y_sum;
    logic signed [ACC_W-1:0]  y_shift;
    logic signed [DATA_W-1:0] y_sat;
    logic                     frame_edge;
    logic                     consume;

    fir_coef_rom u_coef_rom (
        .addr (contador_up),
        .coef (coef)
    );

    assign prod       = PROD_W'(x_q[contador_up]) * PROD_W'(coef);
    assign prod_ext   = ACC_W'(prod);
    assign y_sum      = acc_q + prod_ext;
    assign y_shift    = (y_sum + RND) >>> OUT_SHIFT;
    assign frame_edge = (contador_up == 3'(N_TAPS - 1));

    // In RUN every frame edge shifts the line (repeating pend_data on underrun);
    // in IDLE only when a sample is pending or arriving right now.
    assign consume = frame_edge && ((state_q == ST_RUN) || pend_flag_q || sample_valid);

    always_comb begin
        if (y_shift > SAT_MAX) begin
            y_sat = SAT_MAX[DATA_W-1:0];
        end else if (y_shift < SAT_MIN) begin
            y_sat = SAT_MIN[DATA_W-1:0];
        end else begin
            y_sat = y_shift[DATA_W-1:0];
        end
    end

    always_comb begin
        x_d          = x_q;
        pend_data_d  = pend_data_q;
        pend_flag_d  = pend_flag_q;
        acc_d        = acc_q;
        state_d      = state_q;
        sample_out_d = sample_out_q;
        out_valid_d  = 1'b0;
        overrun_d    = 1'b0;
        underrun_d   = 1'b0;

        if (clear) begin
            x_d         = '{default: '0};
            pend_data_d = '0;
            pend_flag_d = 1'b0;
            acc_d       = '0;
            state_d     = ST_IDLE;
        end else begin
            if (state_q == ST_RUN) begin
                acc_d = (contador_up == '0) ? prod_ext : y_sum;
                if (frame_edge) begin
                    sample_out_d = y_sat;
                    out_valid_d  = 1'b1;
                end
            end

            if (consume) begin
                for (int unsigned k = 1; k < N_TAPS; k++) begin
                    x_d[k] = x_q[k-1];
                end
                // Oldest pending sample wins; a coincident strobe either bypasses
                // straight in (nothing pending) or becomes the new pending sample.
                if (pend_flag_q) begin
                    x_d[0] = pend_data_q;
                end else if (sample_valid) begin
                    x_d[0] = sample_in;
                end else begin
                    x_d[0] = pend_data_q;
                end
                underrun_d = !pend_flag_q && !sample_valid;
                if (sample_valid) begin
                    pend_data_d = sample_in;
                    pend_flag_d = pend_flag_q;
                end else begin
                    pend_flag_d = 1'b0;
                end
                state_d = ST_RUN;
            end else if (sample_valid) begin
                pend_data_d = sample_in;
                pend_flag_d = 1'b1;
                overrun_d   = pend_flag_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q          <= '{default: '0};
            pend_data_q  <= '0;
            pend_flag_q  <= 1'b0;
            acc_q        <= '0;
            state_q      <= ST_IDLE;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            x_q          <= x_d;
            pend_data_q  <= pend_data_d;
            pend_flag_q  <= pend_flag_d;
            acc_q        <= acc_d;
            state_q      <= state_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
            underrun_q   <= underrun_d;
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign overrun    = overrun_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: scenario tasks with a frame-level behavioural model of the
// FIR engine (delay line as an integer array, output as a plain dot product).
module tb_fir_mac_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in = '0;
    logic [2:0]  contador_up = '0;
    logic [15:0] sample_out;
    logic        out_valid, overrun, underrun;

    int errors = 0;
    int checks = 0;

    int coef [8] = '{1024, 3072, 5120, 7168, 7168, 5120, 3072, 1024};

    int          m_x [8];
    int          m_pd;
    bit          m_pf, m_run, m_vld, m_ov, m_ud;
    logic [15:0] m_out = '0;

    always #5 clk = ~clk;

    fir_mac_engine #(.DATA_W(16), .ACC_W(35), .OUT_SHIFT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .contador_up  (contador_up),
        .sample_out   (sample_out),
        .out_valid    (out_valid),
        .overrun      (overrun),
        .underrun     (underrun)
    );

    function automatic logic [15:0] ref_y();
        longint y = 0;
        for (int k = 0; k < 8; k++) y += longint'(m_x[k]) * longint'(coef[k]);
        y = (y + 64'sd16384) >>> 15;
        if (y > 32767) y = 32767;
        else if (y < -32768) y = -32768;
        return y[15:0];
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 8; k++) m_x[k] = 0;
        m_pd = 0; m_pf = 0; m_run = 0; m_vld = 0; m_ov = 0; m_ud = 0;
    endtask

    // One clock: drive inputs, advance the model at the edge, sample #1 later.
    task automatic tick(input bit sv, input logic [15:0] sin, input bit clr);
        bit fe;
        int s;
        int nx;
        sample_valid = sv; sample_in = sin; clear = clr;
        @(posedge clk);
        fe = (contador_up == 3'd7);
        s = int'($signed(sin));
        m_vld = 0; m_ov = 0; m_ud = 0;
        if (!reset) begin
            model_clear(); m_out = '0;
        end else if (clr) begin
            model_clear();
        end else begin
            if (sv && m_pf && !fe) m_ov = 1;
            if (fe && m_run) begin m_out = ref_y(); m_vld = 1; end
            if (fe && (m_run || m_pf || sv)) begin
                nx = m_pf ? m_pd : (sv ? s : m_pd);
                m_ud = !m_pf && !sv;
                for (int k = 7; k > 0; k--) m_x[k] = m_x[k-1];
                m_x[0] = nx;
                if (sv) m_pd = s;
                m_pf = m_pf && sv;
                m_run = 1;
            end else if (sv) begin
                m_pd = s; m_pf = 1;
            end
        end
        #1;
        contador_up = contador_up + 3'd1;
        sample_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic goto_cnt(input logic [2:0] c);
        for (int i = 0; i < 8 && contador_up != c; i++) tick(0, '0, 0);
    endtask

    task automatic test_reset();
        tick(0, '0, 0); tick(0, '0, 0);
        if ({out_valid, overrun, underrun, sample_out} !== 19'b0) begin
            errors++;
            $display("FAIL reset_state: got vld=%b ov=%b ud=%b out=%h, expected all zero", out_valid, overrun, underrun, sample_out);
        end
        checks++;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick(0, '0, 0);
            if ({out_valid, overrun, underrun, sample_out} !== {m_vld, m_ov, m_ud, m_out}) begin
                errors++;
                $display("FAIL idle_after_reset t=%0t: got vld=%b ov=%b ud=%b out=%h, expected vld=%b ov=%b ud=%b out=%h", $time, out_valid, overrun, underrun, sample_out, m_vld, m_ov, m_ud, m_out);
            end
            checks++;
        end
    endtask

    task automatic test_impulse();
        logic [15:0] got [$];
        logic [15:0] exp_seq [9] = '{16'h0400, 16'h0C00, 16'h1400, 16'h1C00, 16'h1C00, 16'h1400, 16'h0C00, 16'h0400, 16'h0000};
        goto_cnt(3'd0);
        for (int i = 0; i < 88; i++) begin
            tick(contador_up == 3'd2, (i < 8) ? 16'h7FFF : 16'h0000, 0);
            if ({out_valid, overrun, underrun, sample_out} !== {m_vld, m_ov, m_ud, m_out}) begin
                errors++;
                $display("FAIL impulse_model t=%0t: got vld=%b ov=%b ud=%b out=%h, expected vld=%b ov=%b ud=%b out=%h", $time, out_valid, overrun, underrun, sample_out, m_vld, m_ov, m_ud, m_out);
            end
            checks++;
            if (out_valid) got.push_back(sample_out);
        end
        for (int k = 0; k < 9; k++) begin
            if (k >= got.size() || got[k] !== exp_seq[k]) begin
                errors++;
                $display("FAIL impulse_seq[%0d]: got %h, expected %h", k, (k < got.size()) ? got[k] : 16'hxxxx, exp_seq[k]);
            end
            checks++;
        end
    endtask

    task automatic test_dc();
        logic [15:0] vals [2] = '{16'h4000, 16'h8000};
        int n;
        for (int p = 0; p < 2; p++) begin
            goto_cnt(3'd0);
            n = 0;
            for (int i = 0; i < 8 * 14; i++) begin
                tick(contador_up == 3'd1, vals[p], 0);
                if ({out_valid, overrun, underrun, sample_out} !== {m_vld, m_ov, m_ud, m_out}) begin
                    errors++;
                    $display("FAIL dc_model t=%0t: got vld=%b ov=%b ud=%b out=%h, expected vld=%b ov=%b ud=%b out=%h", $time, out_valid, overrun, underrun, sample_out, m_vld, m_ov, m_ud, m_out);
                end
                checks++;
                if (out_valid) begin
                    if (n >= 10) begin
                        if (sample_out !== vals[p]) begin
                            errors++;
                            $display("FAIL dc_steady: got %h, expected %h", sample_out, vals[p]);
                        end
                        checks++;
                    end
                    n++;
                end
            end
        end
    endtask

    task automatic test_overrun();
        logic [15:0] va, vb;
        int ov_cnt = 0;
        va = 16'($urandom); vb = 16'($urandom);
        goto_cnt(3'd0);
        for (int i = 0; i < 8; i++) begin
            tick(contador_up == 3'd1 || contador_up == 3'd4, (contador_up == 3'd1) ? va : vb, 0);
            if ({out_valid, overrun, underrun, sample_out} !== {m_vld, m_ov, m_ud, m_out}) begin
                errors++;
                $display("FAIL overrun_model t=%0t: got vld=%b ov=%b ud=%b out=%h, expected vld=%b ov=%b ud=%b out=%h", $time, out_valid, overrun, underrun, sample_out, m_vld, m_ov, m_ud, m_out);
            end
            checks++;
            if (overrun) ov_cnt++;
        end
        if (ov_cnt != 1) begin
            errors++;
            $display("FAIL overrun_count: got %0d, expected 1", ov_cnt);
        end
        checks++;
        for (int i = 0; i < 72; i++) begin
            tick(contador_up == 3'd2, 16'($urandom), 0);
            if ({out_valid, overrun, underrun, sample_out} !== {m_vld, m_ov, m_ud, m_out}) begin
                errors++;
                $display("FAIL overrun_after t=%0t: got vld=%b ov=%b ud=%b out=%h, expected vld=%b ov=%b ud=%b out=%h", $time, out_valid, overrun, underrun, sample_out, m_vld, m_ov, m_ud, m_out);
            end
            checks++;
        end
    endtask

    task automatic test_underrun();
        int ud_cnt = 0;
        bit ud_at_edge = 0;
        bit edge_now;
        goto_cnt(3'd0);
        for (int i = 0; i < 8; i++) tick(contador_up == 3'd2, 16'($urandom), 0);
        for (int i = 0; i < 8; i++) begin
            edge_now = (contador_up == 3'd7);
            tick(0, '0, 0);
            if ({out_valid, overrun, underrun, sample_out} !== {m_vld, m_ov, m_ud, m_out}) begin
                errors++;
                $display("FAIL underrun_model t=%0t: got vld=%b ov=%b ud=%b out=%h, expected vld=%b ov=%b ud=%b out=%h", $time, out_valid, overrun, underrun, sample_out, m_vld, m_ov, m_ud, m_out);
            end
            checks++;
            if (underrun) begin ud_cnt++; ud_at_edge = edge_now; end
        end
        if (ud_cnt != 1 || !ud_at_edge) begin
            errors++;
            $display("FAIL underrun_pulse: got count=%0d at_edge=%b, expected count=1 at_edge=1", ud_cnt, ud_at_edge);
        end
        checks++;
        for (int i = 0; i < 72; i++) begin
            tick(contador_up == 3'd5, 16'($urandom), 0);
            if ({out_valid, overrun, underrun, sample_out} !== {m_vld, m_ov, m_ud, m_out}) begin
                errors++;
                $display("FAIL underrun_repeat t=%0t: got vld=%b ov=%b ud=%b out=%h, expected vld=%b ov=%b ud=%b out=%h", $time, out_valid, overrun, underrun, sample_out, m_vld, m_ov, m_ud, m_out);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        int mode, p1, p2;
        logic [15:0] v1, v2;
        goto_cnt(3'd0);
        for (int f = 0; f < 40; f++) begin
            mode = $urandom_range(0, 3);
            p1 = $urandom_range(0, 7); p2 = $urandom_range(0, 7);
            v1 = 16'($urandom); v2 = 16'($urandom);
            for (int i = 0; i < 8; i++) begin
                tick((mode > 0 && int'(contador_up) == p1) || (mode == 3 && int'(contador_up) == p2),
                     (int'(contador_up) == p1) ? v1 : v2, 0);
                if ({out_valid, overrun, underrun, sample_out} !== {m_vld, m_ov, m_ud, m_out}) begin
                    errors++;
                    $display("FAIL random t=%0t: got vld=%b ov=%b ud=%b out=%h, expected vld=%b ov=%b ud=%b out=%h", $time, out_valid, overrun, underrun, sample_out, m_vld, m_ov, m_ud, m_out);
                end
                checks++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int vld_cnt = 0;
        goto_cnt(3'd3);
        reset = 1'b0;
        model_clear(); m_out = '0;
        #1;
        if ({out_valid, overrun, underrun, sample_out} !== 19'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got vld=%b ov=%b ud=%b out=%h, expected all zero", out_valid, overrun, underrun, sample_out);
        end
        checks++;
        for (int i = 0; i < 5; i++) tick(contador_up == 3'd6, 16'h1234, 0);
        reset = 1'b1;
        for (int i = 0; i < 24; i++) begin
            tick(0, '0, 0);
            if ({out_valid, overrun, underrun, sample_out} !== {m_vld, m_ov, m_ud, m_out}) begin
                errors++;
                $display("FAIL reset_mid_idle t=%0t: got vld=%b ov=%b ud=%b out=%h, expected vld=%b ov=%b ud=%b out=%h", $time, out_valid, overrun, underrun, sample_out, m_vld, m_ov, m_ud, m_out);
            end
            checks++;
            if (out_valid) vld_cnt++;
        end
        if (vld_cnt != 0) begin
            errors++;
            $display("FAIL reset_mid_no_output: got %0d out_valid pulses, expected 0", vld_cnt);
        end
        checks++;
        for (int i = 0; i < 24; i++) begin
            tick(contador_up == 3'd5, 16'($urandom), 0);
            if ({out_valid, overrun, underrun, sample_out} !== {m_vld, m_ov, m_ud, m_out}) begin
                errors++;
                $display("FAIL reset_mid_restart t=%0t: got vld=%b ov=%b ud=%b out=%h, expected vld=%b ov=%b ud=%b out=%h", $time, out_valid, overrun, underrun, sample_out, m_vld, m_ov, m_ud, m_out);
            end
            checks++;
        end
    endtask

    task automatic test_bypass_clear();
        int ud_cnt = 0;
        bit found = 0;
        tick(0, '0, 1);
        goto_cnt(3'd7);
        tick(1, 16'($urandom), 0);
        if (overrun !== 1'b0 || {out_valid, overrun, underrun, sample_out} !== {m_vld, m_ov, m_ud, m_out}) begin
            errors++;
            $display("FAIL bypass_edge: got vld=%b ov=%b ud=%b out=%h, expected vld=%b ov=0 ud=%b out=%h", out_valid, overrun, underrun, sample_out, m_vld, m_ud, m_out);
        end
        checks++;
        for (int i = 0; i < 8; i++) begin
            tick(0, '0, 0);
            if (underrun) ud_cnt++;
        end
        if (ud_cnt != 1) begin
            errors++;
            $display("FAIL bypass_nothing_pending: got %0d underrun pulses, expected 1", ud_cnt);
        end
        checks++;
        for (int i = 0; i < 16; i++) tick(contador_up == 3'd3, 16'($urandom), 0);
        tick(0, '0, 1);
        goto_cnt(3'd2);
        tick(1, 16'h7FFF, 0);
        for (int i = 0; i < 40 && !found; i++) begin
            tick(0, '0, 0);
            if ({out_valid, overrun, underrun, sample_out} !== {m_vld, m_ov, m_ud, m_out}) begin
                errors++;
                $display("FAIL clear_restart_model t=%0t: got vld=%b ov=%b ud=%b out=%h, expected vld=%b ov=%b ud=%b out=%h", $time, out_valid, overrun, underrun, sample_out, m_vld, m_ov, m_ud, m_out);
            end
            checks++;
            if (out_valid) found = 1;
        end
        if (!found || sample_out !== 16'h0400) begin
            errors++;
            $display("FAIL clear_first_output: got found=%b out=%h, expected found=1 out=0400", found, sample_out);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_overrun();
        test_underrun();
        test_random();
        test_reset_mid();
        test_bypass_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
